// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the MEM-stage data port between the pipeline and a secondary (debug/loader) requester
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   p_req/p_we/p_addr/p_wdata    pipeline access; p_stall holds MEM, p_rdata is combinational read data
//   d_req/d_we/d_addr/d_wdata    secondary access; d_gnt on grant, d_rvalid/d_rdata one cycle later
//   mem_addr/mem_wdata/mem_we    data RAM side (word address from addr[RAM_AW+1:2])
//   io_we                        I/O output-register write enable (addr[7] = 1)
//   mem_rdata/io_rdata           RAM and I/O read data
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RAM_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [31:0]       p_addr,
  input  logic [31:0]       p_wdata,
  output logic              p_stall,
  output logic [31:0]       p_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              io_we,
  input  logic [31:0]       mem_rdata,
  input  logic [31:0]       io_rdata
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT - 1);
  logic [3:0]  r_starve_cnt;
  logic        r_d_rvalid;
  logic [31:0] r_d_rdata;
  logic        w_force, w_gnt_d, w_gnt_p, w_any, w_we;
  logic [31:0] w_addr, w_rsel;
  logic        w_unused;
  always_comb begin
    w_force = d_req && (r_starve_cnt == LIM);
    w_gnt_d = !reset && d_req && (!p_req || w_force);
    w_gnt_p = !reset && p_req && !w_gnt_d;
    w_any   = w_gnt_p || w_gnt_d;
    w_addr  = w_gnt_d ? d_addr : p_addr;
    w_we    = w_gnt_d ? d_we : p_we;
    w_rsel  = w_addr[7] ? io_rdata : mem_rdata;
  end
  assign w_unused  = ^w_addr;
  assign d_gnt     = w_gnt_d;
  assign p_stall   = p_req && w_gnt_d;
  assign p_rdata   = w_rsel;
  assign mem_addr  = w_addr[RAM_AW+1:2];
  assign mem_wdata = w_gnt_d ? d_wdata : p_wdata;
  assign mem_we    = w_we && w_any && !w_addr[7];
  assign io_we     = w_we && w_any && w_addr[7];
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  // the counter only advances while the secondary is actually losing; it saturates at the force point
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_d_rvalid   <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_starve_cnt <= (w_gnt_d || !d_req) ? 4'd0 :
                      (w_gnt_p && r_starve_cnt != LIM) ? r_starve_cnt + 4'd1 : r_starve_cnt;
      r_d_rvalid   <= w_gnt_d;
      r_d_rdata    <= w_gnt_d ? w_rsel : r_d_rdata;
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single MEM-stage data port (data RAM plus memory-mapped I/O) between the pipeline MEM stage and a secondary requester (debug/loader port).
- Pipeline has priority. A starvation counter guarantees the secondary port is serviced, at the cost of at most a one-cycle pipeline stall.
- Decodes addr[7] into RAM or I/O write enables, routes read data back to the winner, and returns secondary read data registered with a valid pulse.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the secondary may lose before it is forced a grant (legal range 1..15).
- RAM_AW, 5: RAM word-address width; mem_addr = addr[RAM_AW+1:2].

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p_req  in  1  pipeline MEM access this cycle (load or store).
- p_we  in  1  pipeline store (mwmem).
- p_addr  in  32  pipeline address (malu).
- p_wdata  in  32  pipeline store data.
- p_stall  out  1  pipeline must hold its MEM stage this cycle.
- p_rdata  out  32  pipeline read data, combinational; valid when p_req && !p_stall.
- d_req  in  1  secondary access request; held until d_gnt.
- d_we  in  1  secondary write.
- d_addr  in  32  secondary address.
- d_wdata  in  32  secondary write data.
- d_gnt  out  1  secondary granted this cycle.
- d_rvalid  out  1  one-cycle pulse, one cycle after d_gnt.
- d_rdata  out  32  registered secondary read data, valid with d_rvalid.
- mem_addr  out  RAM_AW  RAM word address.
- mem_wdata  out  32  RAM / I/O write data.
- mem_we  out  1  RAM write enable.
- io_we  out  1  I/O output-register write enable.
- mem_rdata  in  32  RAM read data.
- io_rdata  in  32  I/O input read data.

Behaviour:
- State: starve_cnt (4 bits), d_rvalid register, d_rdata register.
- Force condition: force = d_req && (starve_cnt == STARVE_LIMIT-1).
- Grant (combinational, from current inputs and state):
  - gnt_d = !reset && d_req && (!p_req || force).
  - gnt_p = !reset && p_req && !gnt_d.
- Outputs from the grant:
  - d_gnt = gnt_d.
  - p_stall = p_req && gnt_d; always 0 while reset is high.
- Port mux: the winner's addr, we and wdata drive the memory side. With no grant, the mux selects the pipeline inputs but both write enables are 0.
- Write decode:
  - mem_we = win_we && (gnt_p || gnt_d) && !win_addr[7].
  - io_we = win_we && (gnt_p || gnt_d) && win_addr[7].
- Read select: rsel = win_addr[7] ? io_rdata : mem_rdata.
  - p_rdata = rsel, combinational; equals rsel even when not granted, but only meaningful when gnt_p.
- starve_cnt update, rising edge:
  - reset -> 0.
  - gnt_d or !d_req -> 0.
  - d_req && gnt_p -> +1, saturating at STARVE_LIMIT-1.
  - otherwise (d_req && !p_req && !gnt_d cannot occur) hold.
- Secondary response:
  - d_rvalid <= gnt_d.
  - d_rdata <= gnt_d ? rsel : d_rdata (write grants also update d_rdata and pulse d_rvalid as the write acknowledge).
  - Both cleared to 0 on reset.
- Fairness: after any forced grant starve_cnt = 0, so the pipeline wins at least STARVE_LIMIT-1 cycles before the next forced stall. A pipeline stall never exceeds one consecutive cycle while STARVE_LIMIT ≥ 2. With STARVE_LIMIT = 1 the secondary always wins: documented, not recommended.
- Simultaneous p_req and d_req with the counter below the limit: pipeline wins, d_gnt = 0, starve_cnt increments.
- Secondary dropping d_req without a grant: counter clears; no response is produced.
- Reset asserted mid-operation: same-cycle d_gnt, mem_we and io_we are 0. d_rvalid is 0 the following cycle even if a grant would have occurred. No partial write reaches RAM or I/O.
- Reset values: p_stall = 0, d_gnt = 0, mem_we = 0, io_we = 0, d_rvalid = 0, d_rdata = 0, starve_cnt = 0.

Test Plan:
- Reset, then idle with no requests -> all enables 0, d_rvalid = 0, d_rdata = 0x00000000.
- Only d_req, read at addr 0x08 with RAM word 2 = 0xDEADBEEF -> d_gnt = 1 that cycle, mem_addr = 2; next cycle d_rvalid = 1, d_rdata = 0xDEADBEEF.
- p_req held every cycle and d_req held, STARVE_LIMIT = 4 -> d_gnt asserts on the 4th cycle with p_stall = 1 only on that cycle, then the pipeline wins 3 more cycles.
- Pipeline store to 0x84 with data 0x55 -> io_we = 1, mem_we = 0; pipeline store to 0x04 -> mem_we = 1, io_we = 0, mem_addr = 1.
- Secondary read of 0x80 with io_rdata = 0x1F -> d_rdata = 0x1F one cycle later; a secondary write pulses d_rvalid with no RAM/I/O read side effect.
- Reset asserted in the same cycle as a forced d_gnt with d_we = 1 -> mem_we = 0, next-cycle d_rvalid = 0, starve_cnt = 0.
